// File: rtl/bt_result_to_bin_if.sv
// bt_result_to_bin_if: trit-word input and binary-result output handshakes
interface bt_result_to_bin_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_trits;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_value;
  logic       out_err;
  modport master (output in_valid, in_trits, out_ready, input in_ready, out_valid, out_value, out_err);
  modport slave  (input in_valid, in_trits, out_ready, output in_ready, out_valid, out_value, out_err);
endinterface

// File: rtl/bt_result_to_bin.sv
// bt_result_to_bin: 4-trit balanced ternary to 7-bit two's complement, one trit per clock.
// Define BTCONV_ERRCHK_EN to flag words containing the invalid trit code 2'b00 on out_err.
module bt_result_to_bin (
  input logic clk,
  input logic rst,
  bt_result_to_bin_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [6:0] acc_q, acc_d, val_q, val_d, t;
  logic [1:0] idx_q, idx_d;
  logic       cap;
  assign cap = state_q == IDLE && bus.in_valid;
  always_comb begin
    t = sr_q[7:6] == 2'b10 ? 7'd1 : sr_q[7:6] == 2'b01 ? 7'h7f : 7'd0;
    state_d = state_q;
    sr_d = sr_q;
    acc_d = acc_q;
    idx_d = idx_q;
    val_d = val_q;
    if (cap) begin
      state_d = CONV;
      sr_d = bus.in_trits;
      acc_d = 7'd0;
      idx_d = 2'd3;
    end else if (state_q == CONV) begin
      acc_d = (acc_q << 1) + acc_q + t;
      sr_d = {sr_q[5:0], 2'b00};
      idx_d = idx_q - 2'd1;
      if (idx_q == 2'd0) begin
        state_d = DONE;
        val_d = acc_d;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= 8'd0;
      acc_q <= 7'd0;
      idx_q <= 2'd0;
      val_q <= 7'd0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_value = val_q;
`ifdef BTCONV_ERRCHK_EN
  logic err_q, err_d;
  // The whole word is checked at capture, so the sticky bit only needs loading then.
  assign err_d = cap ? (~|bus.in_trits[7:6] | ~|bus.in_trits[5:4] | ~|bus.in_trits[3:2] | ~|bus.in_trits[1:0]) : err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_bt_result_to_bin.sv
// tb_bt_result_to_bin: directed checks of conversion, latency, backpressure, reset and throughput.
module tb_bt_result_to_bin;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bt_result_to_bin_if bus ();
  bt_result_to_bin dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef BTCONV_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic convert(input logic [7:0] w, input logic [6:0] v, input logic e, input string tag);
    chk({tag, "_in_ready"}, {6'd0, bus.in_ready}, 7'd1);
    bus.in_valid = 1'b1;
    bus.in_trits = w;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy"}, {5'd0, bus.out_valid, bus.in_ready}, 7'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_valid"}, {6'd0, bus.out_valid}, 7'd1);
    chk({tag, "_value"}, bus.out_value, v);
    chk({tag, "_err"}, {6'd0, bus.out_err}, {6'd0, e});
    @(posedge clk); #1;
    chk({tag, "_idle"}, {5'd0, bus.out_valid, bus.in_ready}, 7'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_trits = 8'hff;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_state", {4'd0, bus.out_valid, bus.out_err, bus.in_ready}, 7'd1);
    chk("rst_value", bus.out_value, 7'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    convert(8'b10101010, 7'h28, 1'b0, "p40");
    convert(8'b01010101, 7'h58, 1'b0, "m40");
    convert(8'b11111111, 7'h00, 1'b0, "zero");
    convert(8'b10011110, 7'h13, 1'b0, "p19");
    convert(8'b10001111, 7'h1b, ERR_EXP, "inval");
    convert(8'b11111111, 7'h00, 1'b0, "err_clr");
    // Backpressure on a -2 result with a competing word offered
    bus.in_valid = 1'b1;
    bus.in_trits = 8'b11110110;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_trits = 8'b10101010;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_state", {5'd0, bus.out_valid, bus.in_ready}, 7'd2);
      chk("bp_hold_value", bus.out_value, 7'h7e);
      @(posedge clk); #1;
    end
    chk("bp_still_done", {5'd0, bus.out_valid, bus.in_ready}, 7'd2);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {5'd0, bus.out_valid, bus.in_ready}, 7'd1);
    chk("bp_keep_value", bus.out_value, 7'h7e);
    // Asynchronous reset two cycles into CONV
    bus.in_valid = 1'b1;
    bus.in_trits = 8'b10101010;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", {4'd0, bus.out_valid, bus.out_err, bus.in_ready}, 7'd1);
    chk("arst_value", bus.out_value, 7'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    convert(8'b11111101, 7'h7f, 1'b0, "m1");
    // Back-to-back with in_valid held high
    bus.in_valid = 1'b1;
    bus.in_trits = 8'b10011110;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_cap1", {6'd0, bus.in_ready}, 7'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_val1", {bus.out_valid, bus.out_value[5:0]}, {1'b1, 6'h13});
    chk("b2b_v1_full", bus.out_value, 7'h13);
    @(posedge clk); #1;
    chk("b2b_idle", {6'd0, bus.in_ready}, 7'd1);
    bus.in_trits = 8'b01010101;
    @(posedge clk); #1;
    chk("b2b_cap2", {6'd0, bus.in_ready}, 7'd0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_busy2", {6'd0, bus.out_valid}, 7'd0);
    @(posedge clk); #1;
    chk("b2b_valid2", {6'd0, bus.out_valid}, 7'd1);
    chk("b2b_val2", bus.out_value, 7'h58);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
